// File: rtl/fetch_stage_pkg.sv
// Purpose : shared types and constants for the instruction-fetch stage.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package fetch_stage_pkg;

    // Fetch control FSM, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // sll $0,$0,0 -- the canonical MIPS NOP, used as the bubble instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default instruction memory size in 32-bit words.
    localparam int unsigned DEFAULT_IMEM_DEPTH = 256;

    // IF/ID pipeline register contents (65 bits).
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// Purpose : IF/ID pipeline register {pc4, instr, valid} with load / hold / bubble controls.
// Latency : one clock edge from load_i/bubble_i to ifid_o.
// Backpressure : hold is the default; bubble_i beats load_i when both are asserted.
// Ports   : clk_i, rst_i (sync, active-high), load_i + load_dat_i (capture new entry),
//           bubble_i (overwrite with NOP bubble), ifid_o (registered contents).
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  bubble_i,
    input  ifid_t load_dat_i,
    output ifid_t ifid_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (bubble_i) begin
            ifid_d = IFID_BUBBLE;
        end else if (load_i) begin
            ifid_d = load_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_q <= IFID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Purpose : MIPS instruction-fetch stage: PC, run/pause/halt FSM, imem addressing, IF/ID load.
// Latency : instruction at PC p appears in IF/ID one edge after the cycle with pc_o = p.
// Backpressure : stall_i holds PC, IF/ID and the counter; redirect_i overrides a concurrent stall.
// Ports   : clk_i, rst_i (sync, active-high), start_i (run/pause), stall_i, redirect_i/redirect_pc_i,
//           imem_addr_o/imem_data_i (word-indexed combinational memory), pc_o, ifid_*_o,
//           fetch_cnt_o (saturating count of valid IF/ID loads), fault_o (sticky error).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [31:0] fetch_cnt_o,
    output logic        fault_o
);

    // Byte limit computed one bit wider so a large IMEM_DEPTH cannot wrap the compare.
    localparam logic [32:0] FETCH_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         fault_q, fault_d;

    logic         ifid_load;
    logic         ifid_bubble;
    ifid_t        ifid_new;
    ifid_t        ifid_cur;

    logic [31:0]  pc_plus4;
    logic         pc_out_of_range;

    assign pc_plus4        = pc_q + 32'd4;
    assign pc_out_of_range = ({1'b0, pc_q} >= FETCH_LIMIT);
    assign ifid_new        = '{pc4: pc_plus4, instr: imem_data_i, valid: 1'b1};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The transition edge itself does not fetch.
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!start_i) begin
                    ifid_bubble = 1'b1;
                    state_d     = ST_IDLE;
                end else if (redirect_i) begin
                    ifid_bubble = 1'b1;     // squash the wrong-path fetch
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else if (stall_i) begin
                    // load-use hazard: everything holds
                end else if (pc_out_of_range) begin
                    fault_d     = 1'b1;
                    ifid_bubble = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                    cnt_d     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                end
            end
            ST_HALT: begin
                // frozen until reset
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .load_dat_i (ifid_new),
        .ifid_o     (ifid_cur)
    );

    // Memory is addressed in every state; data is simply ignored when not fetching.
    assign imem_addr_o  = {2'b00, pc_q[31:2]};
    assign pc_o         = pc_q;
    assign ifid_pc4_o   = ifid_cur.pc4;
    assign ifid_instr_o = ifid_cur.instr;
    assign ifid_valid_o = ifid_cur.valid;
    assign fetch_cnt_o  = cnt_q;
    assign fault_o      = fault_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    // DUT A: default depth
    logic        a_rst, a_start, a_stall, a_redir;
    logic [31:0] a_redir_pc, a_addr, a_data, a_pc, a_pc4, a_instr, a_cnt;
    logic        a_valid, a_fault;

    // DUT B: IMEM_DEPTH = 4
    logic        b_rst, b_start, b_stall, b_redir;
    logic [31:0] b_redir_pc, b_addr, b_data, b_pc, b_pc4, b_instr, b_cnt;
    logic        b_valid, b_fault;

    assign a_data = mem[a_addr[7:0]];
    assign b_data = mem[b_addr[7:0]];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(256)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .stall_i(a_stall),
        .redirect_i(a_redir), .redirect_pc_i(a_redir_pc),
        .imem_addr_o(a_addr), .imem_data_i(a_data), .pc_o(a_pc),
        .ifid_pc4_o(a_pc4), .ifid_instr_o(a_instr), .ifid_valid_o(a_valid),
        .fetch_cnt_o(a_cnt), .fault_o(a_fault)
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .stall_i(b_stall),
        .redirect_i(b_redir), .redirect_pc_i(b_redir_pc),
        .imem_addr_o(b_addr), .imem_data_i(b_data), .pc_o(b_pc),
        .ifid_pc4_o(b_pc4), .ifid_instr_o(b_instr), .ifid_valid_o(b_valid),
        .fetch_cnt_o(b_cnt), .fault_o(b_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs changed afterwards apply at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                           input logic [31:0] instr, input logic valid,
                           input logic [31:0] cnt, input logic fault);
        check({tag, ".pc"},    a_pc,    pc);
        check({tag, ".pc4"},   a_pc4,   pc4);
        check({tag, ".instr"}, a_instr, instr);
        check({tag, ".valid"}, {31'h0, a_valid}, {31'h0, valid});
        check({tag, ".cnt"},   a_cnt,   cnt);
        check({tag, ".fault"}, {31'h0, a_fault}, {31'h0, fault});
        check({tag, ".addr"},  a_addr,  {2'b00, pc[31:2]});
    endtask

    task automatic check_b(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                           input logic [31:0] instr, input logic valid,
                           input logic [31:0] cnt, input logic fault);
        check({tag, ".pc"},    b_pc,    pc);
        check({tag, ".pc4"},   b_pc4,   pc4);
        check({tag, ".instr"}, b_instr, instr);
        check({tag, ".valid"}, {31'h0, b_valid}, {31'h0, valid});
        check({tag, ".cnt"},   b_cnt,   cnt);
        check({tag, ".fault"}, {31'h0, b_fault}, {31'h0, fault});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;

        a_rst = 1'b1; a_start = 1'b0; a_stall = 1'b0; a_redir = 1'b0; a_redir_pc = 32'h0;
        b_rst = 1'b1; b_start = 1'b0; b_stall = 1'b0; b_redir = 1'b0; b_redir_pc = 32'h0;

        // 1. reset for 3 cycles, then idle with start low
        for (int i = 0; i < 3; i++) begin
            tick();
            check_a("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        a_rst = 1'b0;
        tick();
        check_a("idle", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // 2. start: first edge only enters RUN
        a_start = 1'b1;
        tick();
        check_a("start_lat", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_a("fetch0", 32'h4, 32'h4, 32'h2008_0005, 1'b1, 32'd1, 1'b0);
        tick();
        check_a("fetch1", 32'h8, 32'h8, 32'h2009_0003, 1'b1, 32'd2, 1'b0);

        // 3. stall two cycles at pc 8
        a_stall = 1'b1;
        tick();
        check_a("stall1", 32'h8, 32'h8, 32'h2009_0003, 1'b1, 32'd2, 1'b0);
        tick();
        check_a("stall2", 32'h8, 32'h8, 32'h2009_0003, 1'b1, 32'd2, 1'b0);
        a_stall = 1'b0;
        tick();
        check_a("fetch2", 32'hC, 32'hC, 32'h0109_5020, 1'b1, 32'd3, 1'b0);

        // 4. redirect beats simultaneous stall
        a_redir = 1'b1; a_redir_pc = 32'h40; a_stall = 1'b1;
        tick();
        check_a("redir", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3, 1'b0);
        a_redir = 1'b0; a_stall = 1'b0;
        tick();
        check_a("fetch16", 32'h44, 32'h44, 32'hA000_0010, 1'b1, 32'd4, 1'b0);

        // 5. misaligned redirect -> HALT, frozen until reset
        a_redir = 1'b1; a_redir_pc = 32'h42;
        tick();
        check_a("misalign", 32'h44, 32'h0, 32'h0, 1'b0, 32'd4, 1'b1);
        a_redir = 1'b0;
        tick();
        tick();
        check_a("halt", 32'h44, 32'h0, 32'h0, 1'b0, 32'd4, 1'b1);
        a_rst = 1'b1;
        tick();
        check_a("halt_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
        a_rst = 1'b0;

        // pause: start low in RUN bubbles IF/ID and returns to IDLE
        tick();
        tick();
        check_a("rerun", 32'h4, 32'h4, 32'h2008_0005, 1'b1, 32'd1, 1'b0);
        a_start = 1'b0;
        tick();
        check_a("pause", 32'h4, 32'h0, 32'h0, 1'b0, 32'd1, 1'b0);
        tick();
        check_a("paused", 32'h4, 32'h0, 32'h0, 1'b0, 32'd1, 1'b0);

        // 6. IMEM_DEPTH = 4: fetch 0..12 then range fault at 16
        check_b("b_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        b_rst = 1'b0; b_start = 1'b1;
        tick();
        check_b("b_start", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_b("b_fetch", 32'(4 * (i + 1)), 32'(4 * (i + 1)), mem[i], 1'b1, 32'(i + 1), 1'b0);
        end
        tick();
        check_b("b_range", 32'h10, 32'h0, 32'h0, 1'b0, 32'd4, 1'b1);
        tick();
        check_b("b_halt", 32'h10, 32'h0, 32'h0, 1'b0, 32'd4, 1'b1);

        // reset mid-RUN
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        tick();
        tick();
        check_b("b_run", 32'h4, 32'h4, 32'h2008_0005, 1'b1, 32'd1, 1'b0);
        b_rst = 1'b1;
        tick();
        check_b("b_midrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
        b_rst = 1'b0;
        tick();
        check_b("b_idle", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
        tick();
        check_b("b_refetch", 32'h4, 32'h4, 32'h2008_0005, 1'b1, 32'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
